// File: rtl/lab4_branch_pkg.sv
// Shared types for the branch update queue: the entry layout and the PC width.
package lab4_branch_pkg;

    localparam int BR_PC_W = 32;

    typedef struct packed {
        logic [BR_PC_W-1:0] pc;
        logic               pred;
    } br_entry_t;

    function automatic logic is_mispredict(input br_entry_t e, input logic taken);
        return e.pred != taken;
    endfunction

endpackage

// File: rtl/lab4_branch_update_queue_buf.sv
// Circular entry store for in-flight branches, with head/tail pointers.
// Each pointer has one extra wrap bit so that full and empty can be told apart.
module lab4_branch_update_queue_buf
    import lab4_branch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      i_push,
    input  br_entry_t i_push_data,
    input  logic      i_pop,
    input  logic      i_clear,
    output logic      o_full,
    output logic      o_empty,
    output br_entry_t o_head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] r_head;
    logic [AW:0] r_tail;
    br_entry_t   r_mem [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign o_empty   = (r_head == r_tail);
    assign o_full    = (r_head[AW-1:0] == r_tail[AW-1:0]) && (r_head[AW] != r_tail[AW]);
    assign o_head    = r_mem[r_head[AW-1:0]];
    assign w_do_push = i_push && !o_full && !i_clear;
    assign w_do_pop  = i_pop && !o_empty && !i_clear;

    always_ff @(posedge clk) begin
        if (!reset || i_clear) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_do_push) r_tail <= r_tail + 1'b1;
            if (w_do_pop)  r_head <= r_head + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_tail[AW-1:0]] <= i_push_data;
    end

endmodule

// File: rtl/lab4_branch_update_queue.sv
// In-order queue of predicted branches between fetch and execute.
// Resolves the oldest entry, drives the gshare update one cycle later, and keeps mispredict statistics.
module lab4_branch_update_queue
    import lab4_branch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enq_val,
    output logic               enq_rdy,
    input  logic [BR_PC_W-1:0] enq_pc,
    input  logic               enq_pred,
    input  logic               res_val,
    output logic               res_rdy,
    input  logic [BR_PC_W-1:0] res_pc,
    input  logic               res_taken,
    input  logic               flush,
    output logic               upd_en,
    output logic               upd_val,
    output logic [BR_PC_W-1:0] upd_pc,
    output logic               mispred,
    output logic               order_err,
    output logic [31:0]        num_br,
    output logic [31:0]        num_misp
);

    logic      w_full;
    logic      w_empty;
    br_entry_t w_head;
    br_entry_t w_enq_entry;
    logic      w_enq_fire;
    logic      w_res_fire;
    logic      w_upd_fire;
    logic      w_misp;
    logic      w_clear;

    logic               r_upd_en;
    logic               r_upd_val;
    logic [BR_PC_W-1:0] r_upd_pc;
    logic               r_mispred;
    logic               r_order_err;
    logic [31:0]        r_num_br;
    logic [31:0]        r_num_misp;

    assign enq_rdy     = !w_full;
    assign res_rdy     = !w_empty;
    assign w_enq_fire  = enq_val && !w_full;
    assign w_res_fire  = res_val && !w_empty;
    // flush suppresses the resolve entirely, so no update and no statistics.
    assign w_upd_fire  = w_res_fire && !flush;
    assign w_misp      = w_upd_fire && is_mispredict(w_head, res_taken);
    // A mispredict squashes every younger entry, including one enqueued this cycle.
    assign w_clear     = flush || w_misp;
    assign w_enq_entry = '{pc: enq_pc, pred: enq_pred};

    lab4_branch_update_queue_buf #(
        .DEPTH(DEPTH)
    ) u_buf (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_enq_fire),
        .i_push_data (w_enq_entry),
        .i_pop       (w_upd_fire),
        .i_clear     (w_clear),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_head      (w_head)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_upd_en    <= 1'b0;
            r_upd_val   <= 1'b0;
            r_upd_pc    <= '0;
            r_mispred   <= 1'b0;
            r_order_err <= 1'b0;
            r_num_br    <= '0;
            r_num_misp  <= '0;
        end else begin
            r_upd_en  <= w_upd_fire;
            r_mispred <= w_misp;
            if (w_upd_fire) begin
                r_upd_val <= res_taken;
                r_upd_pc  <= w_head.pc;
                r_num_br  <= r_num_br + 32'd1;
                if (res_pc != w_head.pc) r_order_err <= 1'b1;
            end
            if (w_misp) r_num_misp <= r_num_misp + 32'd1;
        end
    end

    assign upd_en    = r_upd_en;
    assign upd_val   = r_upd_val;
    assign upd_pc    = r_upd_pc;
    assign mispred   = r_mispred;
    assign order_err = r_order_err;
    assign num_br    = r_num_br;
    assign num_misp  = r_num_misp;

endmodule

// File: tb/tb_lab4_branch_update_queue.sv
// Randomized bench for the branch update queue against a queue-based behavioural model.
module tb_lab4_branch_update_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enq_val = 1'b0;
    logic        enq_rdy;
    logic [31:0] enq_pc = '0;
    logic        enq_pred = 1'b0;
    logic        res_val = 1'b0;
    logic        res_rdy;
    logic [31:0] res_pc = '0;
    logic        res_taken = 1'b0;
    logic        flush = 1'b0;
    logic        upd_en;
    logic        upd_val;
    logic [31:0] upd_pc;
    logic        mispred;
    logic        order_err;
    logic [31:0] num_br;
    logic [31:0] num_misp;

    int errors = 0;
    int checks = 0;

    lab4_branch_update_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .enq_val   (enq_val),
        .enq_rdy   (enq_rdy),
        .enq_pc    (enq_pc),
        .enq_pred  (enq_pred),
        .res_val   (res_val),
        .res_rdy   (res_rdy),
        .res_pc    (res_pc),
        .res_taken (res_taken),
        .flush     (flush),
        .upd_en    (upd_en),
        .upd_val   (upd_val),
        .upd_pc    (upd_pc),
        .mispred   (mispred),
        .order_err (order_err),
        .num_br    (num_br),
        .num_misp  (num_misp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: each entry is {pc, pred}; front of the queue is the oldest branch.
    logic [32:0] mq[$];
    bit          m_init = 0;
    bit          m_upd_en, m_upd_val, m_mispred, m_order_err;
    logic [31:0] m_upd_pc, m_nbr, m_nmisp;

    always @(posedge clk) begin
        if (!reset) begin
            mq.delete();
            m_init = 1; m_upd_en = 0; m_upd_val = 0; m_upd_pc = 0;
            m_mispred = 0; m_order_err = 0; m_nbr = 0; m_nmisp = 0;
        end else if (m_init) begin
            bit ef, rf, mis;
            logic [32:0] h;
            ef = enq_val && (mq.size() < DEPTH);
            rf = res_val && (mq.size() > 0);
            m_upd_en = 0;
            m_mispred = 0;
            if (flush) begin
                mq.delete();
            end else begin
                mis = 0;
                if (rf) begin
                    h = mq.pop_front();
                    mis = (h[0] != res_taken);
                    m_upd_en = 1; m_upd_val = res_taken; m_upd_pc = h[32:1];
                    m_mispred = mis;
                    m_nbr = m_nbr + 1;
                    if (mis) m_nmisp = m_nmisp + 1;
                    if (res_pc != h[32:1]) m_order_err = 1;
                end
                if (mis) mq.delete();
                else if (ef) mq.push_back({enq_pc, enq_pred});
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("enq_rdy", {31'b0, enq_rdy}, {31'b0, mq.size() < DEPTH});
            chk("res_rdy", {31'b0, res_rdy}, {31'b0, mq.size() > 0});
            chk("upd_en", {31'b0, upd_en}, {31'b0, m_upd_en});
            chk("mispred", {31'b0, mispred}, {31'b0, m_mispred});
            chk("order_err", {31'b0, order_err}, {31'b0, m_order_err});
            chk("num_br", num_br, m_nbr);
            chk("num_misp", num_misp, m_nmisp);
            if (m_upd_en) begin
                chk("upd_val", {31'b0, upd_val}, {31'b0, m_upd_val});
                chk("upd_pc", upd_pc, m_upd_pc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        enq_val = 0; res_val = 0; flush = 0;
    endtask

    initial begin
        // Reset held with enq_val asserted
        reset = 0; enq_val = 1; enq_pc = 32'h100;
        repeat (3) tick();
        chk("rst_enq_rdy", {31'b0, enq_rdy}, 32'd1);
        chk("rst_res_rdy", {31'b0, res_rdy}, 32'd0);
        chk("rst_upd_en", {31'b0, upd_en}, 32'd0);
        chk("rst_num_br", num_br, 32'd0);
        reset = 1; idle();

        // Correct prediction
        enq_val = 1; enq_pc = 32'h100; enq_pred = 1; tick();
        idle(); res_val = 1; res_pc = 32'h100; res_taken = 1; tick();
        chk("ok_upd_en", {31'b0, upd_en}, 32'd1);
        chk("ok_upd_val", {31'b0, upd_val}, 32'd1);
        chk("ok_upd_pc", upd_pc, 32'h100);
        chk("ok_mispred", {31'b0, mispred}, 32'd0);
        chk("ok_num_br", num_br, 32'd1);
        idle();

        // Mispredict squashes younger entries
        enq_val = 1; enq_pc = 32'h100; enq_pred = 1; tick();
        enq_pc = 32'h104; enq_pred = 0; tick();
        enq_pc = 32'h108; enq_pred = 1; tick();
        idle(); res_val = 1; res_pc = 32'h100; res_taken = 0; tick();
        chk("mp_mispred", {31'b0, mispred}, 32'd1);
        chk("mp_num_misp", num_misp, 32'd1);
        chk("mp_res_rdy", {31'b0, res_rdy}, 32'd0);
        idle(); tick();
        chk("mp_mispred_pulse", {31'b0, mispred}, 32'd0);

        // Fill to full, then stream across the pointer wrap
        for (int i = 0; i < 5; i++) begin
            enq_val = 1; enq_pc = 32'h300 + 32'(4 * i); enq_pred = i[0];
            tick();
            if (i == 3) chk("full_enq_rdy", {31'b0, enq_rdy}, 32'd0);
        end
        for (int i = 0; i < 8; i++) begin
            enq_val = 1; enq_pc = 32'h400 + 32'(4 * i); enq_pred = i[1];
            res_val = 1; res_pc = mq[0][32:1]; res_taken = mq[0][0];
            tick();
            if (i == 0) begin
                chk("wrap_first_pc", upd_pc, 32'h300);
                chk("full_simul_no_enq", {31'b0, enq_rdy}, 32'd1);
            end
        end

        // Flush wins over a resolve
        idle(); res_val = 1; res_pc = mq[0][32:1]; res_taken = mq[0][0]; flush = 1; enq_val = 1;
        tick();
        chk("fl_upd_en", {31'b0, upd_en}, 32'd0);
        chk("fl_res_rdy", {31'b0, res_rdy}, 32'd0);
        idle();

        // Order check
        enq_val = 1; enq_pc = 32'h200; enq_pred = 1; tick();
        idle(); res_val = 1; res_pc = 32'h204; res_taken = 1; tick();
        chk("ord_err", {31'b0, order_err}, 32'd1);
        chk("ord_upd_pc", upd_pc, 32'h200);
        idle(); tick(); tick();
        chk("ord_sticky", {31'b0, order_err}, 32'd1);

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 600; i++) begin
            reset     = ($urandom_range(0, 99) != 0);
            enq_val   = ($urandom_range(0, 2) != 0);
            enq_pc    = {$urandom_range(0, 32'h3FFF), 2'b00};
            enq_pred  = $urandom_range(0, 1);
            res_val   = ($urandom_range(0, 1) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            if (mq.size() > 0) begin
                res_pc    = ($urandom_range(0, 15) != 0) ? mq[0][32:1] : $urandom;
                res_taken = ($urandom_range(0, 3) != 0) ? mq[0][0] : !mq[0][0];
            end else begin
                res_pc    = $urandom;
                res_taken = $urandom_range(0, 1);
            end
            tick();
        end

        // Reset with a resolve pending: no update afterwards
        reset = 1; idle();
        enq_val = 1; enq_pc = 32'h500; enq_pred = 0; tick();
        idle(); res_val = 1; res_pc = 32'h500; res_taken = 0; reset = 0; tick();
        chk("rst_mid_upd_en", {31'b0, upd_en}, 32'd0);
        chk("rst_mid_res_rdy", {31'b0, res_rdy}, 32'd0);
        reset = 1; idle(); tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
